// File: rtl/seq_det_pkg.sv
// Shared constants and masked-compare helper for the parametrised serial-pattern detector.
// The match counter is built only when SEQDET_COUNT_EN is defined.
package seq_det_pkg;

  localparam int unsigned SEQDET_PAT_W   = 8;
  localparam int unsigned SEQDET_CNT_W   = 8;
  localparam int unsigned SEQDET_MAX_W   = 64;
  localparam logic [3:0]  SEQDET_RST_PAT = 4'b1101;
  localparam int unsigned SEQDET_RST_LEN = 4;

  // True when the low `len` bits of a and b agree; len >= SEQDET_MAX_W compares everything.
  function automatic logic seq_det_masked_eq(
    input logic [SEQDET_MAX_W-1:0] a,
    input logic [SEQDET_MAX_W-1:0] b,
    input int unsigned             len
  );
    logic [SEQDET_MAX_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < SEQDET_MAX_W; i++) begin
      mask[i] = (i < len);
    end
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Combinational masked comparator: hit when the low cfg_len bits of cand equal cfg_pat.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = SEQDET_PAT_W,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] cand,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             hit
);

  assign hit = seq_det_masked_eq(SEQDET_MAX_W'(cand), SEQDET_MAX_W'(cfg_pat), 32'(cfg_len));

endmodule

// File: rtl/seq_detector_param.sv
// Mealy detector for a run-time programmable serial pattern of 1..PAT_W bits.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = SEQDET_PAT_W,
  parameter int unsigned CNT_W = SEQDET_CNT_W,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  logic [PAT_W-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic             cfg_ovl_q, cfg_ovl_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;

  logic [PAT_W-1:0] cand;
  logic             hit;
  logic             fill_ok;
  logic             match_c;

  assign cand    = {hist_q[PAT_W-2:0], x};
  assign fill_ok = (32'(fill_q) + 32'd1) >= 32'(cfg_len_q);

  seq_det_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .cand    (cand),
    .cfg_pat (cfg_pat_q),
    .cfg_len (cfg_len_q),
    .hit     (hit)
  );

  // A config load swallows the bit offered in the same cycle, so it can never match.
  assign match_c = reset_n & x_valid & ~cfg_load & ~cfg_err_q & fill_ok & hit;
  assign y       = match_c;
  assign cfg_err = cfg_err_q;

  always_comb begin
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (cfg_load) begin
      cfg_pat_d = pattern;
      cfg_len_d = pat_len;
      cfg_ovl_d = overlap;
      cfg_err_d = (pat_len == '0) || (32'(pat_len) > PAT_W);
      hist_d    = '0;
      fill_d    = '0;
    end else if (x_valid) begin
      if (match_c && !cfg_ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand;
        if (fill_q != LEN_W'(PAT_W)) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pat_q <= PAT_W'(SEQDET_RST_PAT);
      cfg_len_q <= LEN_W'(SEQDET_RST_LEN);
      cfg_ovl_q <= 1'b1;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
    end else begin
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle match; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a randomized stream
// checked against a queue-based model of the matching rules.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = 4;
  localparam int          CNT_MAX = 3;
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             x;
  logic             x_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             cfg_err;

  logic [PAT_W-1:0] cmp_cand;
  logic [PAT_W-1:0] cmp_pat;
  logic [LEN_W-1:0] cmp_len;
  logic             cmp_hit;

  int errors;
  int checks;
  int cyc;

  // Reference model state: accepted bits since the last clear, oldest first.
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_err;
  int               m_cnt;
  bit               m_q[$];

  seq_detector_param #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  seq_det_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_ref_cmp (
    .cand    (cmp_cand),
    .cfg_pat (cmp_pat),
    .cfg_len (cmp_len),
    .hit     (cmp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pat = 8'b0000_1101;
    m_len = 4;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    m_q.delete();
  endtask

  function automatic bit model_y(bit xi, bit xv, bit ld);
    bit b;
    if (!xv || ld || m_err) return 1'b0;
    if (m_q.size() + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? xi : m_q[m_q.size() - k];
      if (b != m_pat[3'(k)]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one cycle, sample y mid-cycle, then advance the model past the edge.
  task automatic step(input bit xi, input bit xv, input bit ld, input logic [7:0] pat,
                      input int len, input bit ovl, input bit clr,
                      output logic gy, output bit wy);
    x = xi; x_valid = xv; cfg_load = ld; pattern = pat;
    pat_len = 4'(len); overlap = ovl; cnt_clr = clr;
    wy = model_y(xi, xv, ld);
    @(negedge clk);
    gy = y;
    @(posedge clk);
    if (ld) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_err = (len == 0) || (len > int'(PAT_W));
      m_q.delete();
    end else if (xv) begin
      if (wy && !m_ovl) m_q.delete();
      else begin
        m_q.push_back(xi);
        if (m_q.size() > int'(PAT_W)) void'(m_q.pop_front());
      end
    end
    if (CNT_EN) begin
      if (clr) m_cnt = 0;
      else if (wy && m_cnt < CNT_MAX) m_cnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    x = 1'b1; x_valid = 1'b1; cfg_load = 1'b0; pattern = '0; pat_len = '0;
    overlap = 1'b0; cnt_clr = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL reset_y got=%b want=0", y); end
    checks++; if (match_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", match_count); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    x_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_default_overlap();
    logic [6:0] s = 7'b1101101;
    logic gy; bit wy;
    for (int i = 0; i < 7; i++) begin
      step(s[3'(6 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== ((i == 3) || (i == 6))) begin errors++; $display("FAIL default_ovl_y bit=%0d got=%b want=%b", i + 1, gy, (i == 3) || (i == 6)); end
    end
    checks++;
    if (match_count !== 2'(CNT_EN ? 2 : 0)) begin errors++; $display("FAIL default_ovl_count got=%0d want=%0d", match_count, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s = 7'b1101101;
    logic gy; bit wy;
    step(1'b1, 1'b1, 1'b1, 8'b1101, 4, 1'b0, 1'b1, gy, wy);
    checks++; if (gy !== 1'b0) begin errors++; $display("FAIL nonovl_load_y got=%b want=0", gy); end
    for (int i = 0; i < 7; i++) begin
      step(s[3'(6 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== (i == 3)) begin errors++; $display("FAIL nonovl_y bit=%0d got=%b want=%b", i + 1, gy, i == 3); end
    end
    checks++;
    if (match_count !== 2'(CNT_EN ? 1 : 0)) begin errors++; $display("FAIL nonovl_count got=%0d want=%0d", match_count, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_gaps();
    bit xs[7] = '{1, 1, 1, 0, 1, 0, 1};
    bit vs[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic gy; bit wy;
    step(1'b0, 1'b0, 1'b1, 8'b1101, 4, 1'b1, 1'b0, gy, wy);
    for (int i = 0; i < 7; i++) begin
      step(xs[i], vs[i], 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== (i == 6)) begin errors++; $display("FAIL gaps_y cyc=%0d got=%b want=%b", i, gy, i == 6); end
    end
  endtask

  task automatic test_len8_and_err();
    logic [15:0] s = 16'hA5A5;
    logic gy; bit wy;
    step(1'b0, 1'b0, 1'b1, 8'hA5, 8, 1'b1, 1'b0, gy, wy);
    for (int i = 0; i < 16; i++) begin
      step(s[4'(15 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== ((i == 7) || (i == 15))) begin errors++; $display("FAIL len8_y bit=%0d got=%b want=%b", i + 1, gy, (i == 7) || (i == 15)); end
    end
    step(1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 1'b0, gy, wy);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL len0_cfg_err got=%b want=1", cfg_err); end
    for (int i = 0; i < 16; i++) begin
      step(s[4'(15 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== 1'b0) begin errors++; $display("FAIL len0_y bit=%0d got=%b want=0", i + 1, gy); end
    end
  endtask

  task automatic test_count_sat();
    int want[5] = '{1, 2, 3, 3, 3};
    logic gy; bit wy;
    step(1'b1, 1'b1, 1'b1, 8'h01, 1, 1'b1, 1'b1, gy, wy);
    checks++; if (gy !== 1'b0) begin errors++; $display("FAIL sat_load_discard_y got=%b want=0", gy); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== 1'b1 || match_count !== 2'(CNT_EN ? want[i] : 0)) begin
        errors++; $display("FAIL sat_count bit=%0d y=%b count=%0d want_count=%0d", i + 1, gy, match_count, CNT_EN ? want[i] : 0);
      end
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, gy, wy);
    checks++;
    if (gy !== 1'b1 || match_count !== 2'd0) begin errors++; $display("FAIL clr_priority y=%b count=%0d want y=1 count=0", gy, match_count); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre = 3'b110;
    logic [4:0] post = 5'b11101;
    logic gy; bit wy;
    step(1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, gy, wy);
    for (int i = 0; i < 3; i++) step(pre[2'(2 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
    x = 1'b1; x_valid = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL mid_reset_y got=%b want=0", y); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    x_valid = 1'b0;
    model_reset();
    checks++; if (cfg_err !== 1'b0 || match_count !== 2'd0) begin errors++; $display("FAIL mid_reset_state cfg_err=%b count=%0d want 0/0", cfg_err, match_count); end
    for (int i = 0; i < 5; i++) begin
      step(post[3'(4 - i)], 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, gy, wy);
      checks++;
      if (gy !== (i == 4)) begin errors++; $display("FAIL mid_reset_y bit=%0d got=%b want=%b", i + 1, gy, i == 4); end
    end
  endtask

  task automatic test_random();
    logic gy; bit wy;
    bit ld, clr;
    int len;
    for (int i = 0; i < 1500; i++) begin
      ld  = ($urandom_range(0, 99) < 4);
      clr = ($urandom_range(0, 99) < 3);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
      step(1'($urandom), ($urandom_range(0, 3) != 0), ld, 8'($urandom), len, 1'($urandom), clr, gy, wy);
      checks++;
      if (gy !== wy) begin errors++; $display("FAIL rand_y cyc=%0d got=%b want=%b", cyc, gy, wy); end
      checks++;
      if (match_count !== 2'(m_cnt) || cfg_err !== m_err) begin
        errors++; $display("FAIL rand_state cyc=%0d count=%0d want=%0d cfg_err=%b want=%b", cyc, match_count, m_cnt, cfg_err, m_err);
      end
    end
  endtask

  task automatic test_cmp();
    int l;
    logic [7:0] mask;
    bit want;
    for (int i = 0; i < 200; i++) begin
      cmp_cand = 8'($urandom);
      l = $urandom_range(0, 9);
      cmp_pat = ($urandom_range(0, 1) == 0) ? cmp_cand ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      cmp_len = 4'(l);
      mask = (l >= 8) ? 8'hFF : 8'((1 << l) - 1);
      want = ((cmp_cand ^ cmp_pat) & mask) == 8'h00;
      #1;
      checks++;
      if (cmp_hit !== want) begin errors++; $display("FAIL cmp_hit cand=%h pat=%h len=%0d got=%b want=%b", cmp_cand, cmp_pat, l, cmp_hit, want); end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    cmp_cand = '0; cmp_pat = '0; cmp_len = '0;
    model_reset();
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_gaps();
    test_len8_and_err();
    test_count_sat();
    test_reset_mid();
    test_random();
    test_cmp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector. It replaces the fixed-pattern 4-bit detectors in the sequence-detection library. It watches a qualified serial bit stream and flags the bit that completes a run-time-programmable pattern of 1..PAT_W bits. Overlapping or non-overlapping matching is selectable, and an optional saturating match counter is included. It sits directly behind the serial receive front end and drives event/interrupt logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- LEN_W, $clog2(PAT_W+1): width of the length field (derived; not overridden).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  qualifies x; the bit is consumed on a rising clk edge with x_valid=1.
- cfg_load  in  1  one-cycle strobe that captures pattern/pat_len/overlap.
- pattern  in  PAT_W  target pattern. pattern[pat_len-1] is the first bit received; pattern[0] is the last.
- pat_len  in  LEN_W  pattern length, 1..PAT_W.
- overlap  in  1  1 = overlapping detection, 0 = restart after a match.
- cnt_clr  in  1  synchronous clear of match_count.
- y  out  1  Mealy match flag.
- match_count  out  CNT_W  saturating number of matches.
- cfg_err  out  1  captured pat_len is illegal (0 or >PAT_W).

## Operation
- Config registers: cfg_pat, cfg_len, cfg_ovl.
  - Reset values: cfg_pat = PAT_W'b1101 (zero-extended), cfg_len = 4, cfg_ovl = 1.
- History register hist[PAT_W-1:0] holds the most recent bit at hist[0]. fill[LEN_W-1:0] counts valid history bits, saturating at PAT_W.
- Candidate cand = {hist[PAT_W-2:0], x}.
- Match condition: x_valid && !cfg_err && (fill+1 ≥ cfg_len) && (cand[cfg_len-1:0] == cfg_pat[cfg_len-1:0]). Only the low cfg_len bits are compared.
- y = match condition (combinational, same cycle as the completing bit).
- On an accepted bit without a match: hist ← cand; fill ← min(fill+1, PAT_W).
- On a match:
  - cfg_ovl=1: hist ← cand and fill advances; later matches may share bits with this one.
  - cfg_ovl=0: hist ← 0 and fill ← 0; the next match needs cfg_len fresh bits.
- x_valid=0: hist and fill hold; y=0.
- cfg_load=1: config registers capture the inputs, hist ← 0, fill ← 0, and any bit offered that cycle is discarded. y is forced 0 in the cfg_load cycle.
- cfg_err = (cfg_len==0) || (cfg_len>PAT_W), registered with the config. While it is set, y stays 0; the history still shifts.
- Counter:
  - Increments on every cycle with y=1 and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release assumed upstream): hist=0, fill=0, match_count=0, cfg_err=0, config at reset values. y is forced 0 while reset_n=0.
- Reset mid-stream discards all partial progress; the first match after release needs cfg_len fresh valid bits.
- Latency: y asserts in the same cycle as the completing bit (0 cycles). match_count reflects a match one edge later.
- New config applies to the first bit after the cfg_load edge.
- A fixed pattern with overlap=1 and len=4 produces exactly the same y sequence as the legacy 1101 detector for any stream.

## Configuration
- SEQDET_COUNT_EN defined: match_count counter and the cnt_clr logic are built as described.
- Undefined: no counter flops, match_count tied to 0, cnt_clr ignored. y and cfg_err are unaffected.

## Structure
- Package seq_det_pkg holds:
  - default PAT_W/CNT_W;
  - the reset pattern constant SEQDET_RST_PAT = 'b1101 and SEQDET_RST_LEN = 4;
  - a function computing the masked compare for a given length.
- Sub-module seq_det_cmp: combinational masked comparator (cand, cfg_pat, cfg_len → hit). It is instantiated once and reused by the bench as a reference-model check.

## Test plan
- Defaults after reset, overlap=1, stream 1,1,0,1,1,0,1 (all valid) → y=1 on bits 4 and 7 only; match_count=2.
- cfg_load with pattern=1101, len=4, overlap=0, then the same stream → y=1 on bit 4 only; match_count=1.
- Stream 1,1,0,1 with x_valid low for 3 cycles between bits 2 and 3 → y=1 only on the cycle bit 4 is valid; y=0 during the gaps.
- PAT_W=8, pattern=8'hA5, len=8, stream 0xA5A5 (MSB first), overlap=1 → matches on bits 8 and 16. Then len=0 → cfg_err=1 and y never asserts.
- CNT_W=2, pattern=1, len=1, five consecutive valid 1s → match_count 1,2,3,3,3. cnt_clr asserted with a match → count 0.
- reset_n pulsed low after bits 1,1,0 of 1101, then bit 1 → no y. A full 1101 sent afterwards → y on its last bit; config back to reset values.
